// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main entry plus one skid entry between adjacent stages.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 beat/cycle.
// Backpressure: in_ready comes only from registered skid state and rst, never from out_ready.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   flush               kill held and incoming entries this cycle
//   in_valid/in_ready   upstream handshake; in_ctrl/in_dst/in_data payload
//   out_valid/out_ready downstream handshake; out_ctrl/out_dst/out_data payload
//   stall_cnt/flush_cnt 32-bit saturating event counters, present only when
//                       PIPE_STAGE_REG_STATS_EN is defined
module pipe_stage_reg #(
    parameter int CTRL_W = 4,
    parameter int DST_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DST_W-1:0]  in_dst,
    input  logic [DATA_W-1:0] in_data,
`ifdef PIPE_STAGE_REG_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DST_W-1:0]  out_dst,
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DST_W-1:0]  main_dst;
    logic [DATA_W-1:0] main_data;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DST_W-1:0]  skid_dst;
    logic [DATA_W-1:0] skid_data;

    logic accept;
    logic send;

    assign in_ready = ~skid_valid & ~rst;
    assign accept   = in_valid & in_ready;
    assign send     = main_valid & out_ready;

    assign out_valid = main_valid;
    // A bubble must never carry live control bits (RegWrite/MemWrite) downstream.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_dst   = main_dst;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_dst   <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_dst   <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // dst/data keep their old contents; only validity and control are killed.
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low here, so no new beat can arrive this cycle.
            if (send) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_dst   <= skid_dst;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || send) begin
            main_valid <= accept;
            if (accept) begin
                main_ctrl <= in_ctrl;
                main_dst  <= in_dst;
                main_data <= in_data;
            end
        end else if (accept) begin
            // Main is held by downstream: park the new beat behind it.
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_dst   <= in_dst;
            skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (main_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (main_valid || skid_valid) && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
